circle_draw: RTL and testbench
==============================

Name: circle_draw

Overview:
- Bresenham/midpoint circle rasteriser that drives the 160x120, 3-bit-colour VGA adapter pixel-write port (x, y, colour, plot).
- Sits in the same slot as the screen-fill stage. Top-level sequencing runs the fill first, then this block.
- Emits one pixel write per clock. Pixels outside the screen are suppressed. Reports completion on done.

Parameters:
- SCREEN_W, 160, horizontal pixel count; valid x is 0..SCREEN_W-1.
- SCREEN_H, 120, vertical pixel count; valid y is 0..SCREEN_H-1.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  level request; sampled only in IDLE.
- centre_x  in  8  circle centre x; latched at start.
- centre_y  in  7  circle centre y; latched at start.
- radius  in  8  radius 0..255; latched at start.
- colour_in  in  3  pixel colour; latched at start.
- x  out  8  pixel x to adapter.
- y  out  7  pixel y to adapter.
- colour  out  3  pixel colour to adapter.
- plot  out  1  write strobe; 1 = write (x,y,colour) this cycle.
- done  out  1  drawing complete.

Behaviour:
- Reset (Reset=0, asynchronous, takes effect immediately, also mid-draw):
  - state=IDLE; x=0, y=0, colour=0, plot=0, done=0; all internal registers cleared.
  - After release, the block waits for a new start; no pixels are written.
- States and transitions:
  - IDLE: start=1 latches inputs -> INIT.
  - INIT (1 cycle): ox=radius, oy=0, crit=1-radius, oct=0 -> PLOT.
  - PLOT: one octant point per cycle, oct 0..7.
    - At oct=7, update the algorithm registers.
    - If oy>ox after the update -> DONE; else oct=0 and stay in PLOT.
  - DONE: done=1; -> IDLE when start=0. done is held while start stays 1, so one start level draws exactly once.
- Octant order, with cx,cy the latched centre:
  - 0: (cx+ox, cy+oy)
  - 1: (cx+oy, cy+ox)
  - 2: (cx-ox, cy+oy)
  - 3: (cx-oy, cy+ox)
  - 4: (cx-ox, cy-oy)
  - 5: (cx-oy, cy-ox)
  - 6: (cx+ox, cy-oy)
  - 7: (cx+oy, cy-ox)
- Update at oct=7:
  - oy = oy+1.
  - If crit<=0: crit = crit + 2*oy_new + 1.
  - Else: ox = ox-1, then crit = crit + 2*(oy_new-ox_new) + 1.
- Widths:
  - Coordinate sums are computed as 10-bit signed.
  - crit is 12-bit signed; no overflow for radius<=255.
- Clipping:
  - If a computed px<0 or px>=SCREEN_W, or py<0 or py>=SCREEN_H: plot=0 for that cycle, and x,y hold their previous values.
  - The cycle is still consumed, so timing is data-independent.
- Outputs are registered:
  - The point computed in PLOT cycle k appears on x/y/colour/plot at the following edge, for exactly one cycle.
  - Outside PLOT-driven cycles, plot=0.
- Latency:
  - start sampled at edge E0; INIT at E1; the first pixel (oct 0) is visible after E2.
  - Pixels then follow at one per clock for 8*N cycles, N = loop iterations.
  - done=1 after the edge following the last pixel's visible cycle.
- Duplicates (e.g. oy=0 or oy=ox) are written again, not filtered.
- start pulses during INIT, PLOT or DONE are ignored. Input changes after the latch have no effect.
- colour output = latched colour_in on every plot=1 cycle.

Test Plan:
- radius=0, centre (80,60), colour 3'b101 -> 8 consecutive plot=1 cycles, all at (80,60) colour 5; first one 2 edges after start; done rises next edge.
- radius=1, centre (80,60):
  - N=2, so 16 pixel cycles.
  - First 8 points: (81,60),(80,61),(79,60),(80,61),(79,60),(80,59),(81,60),(80,59).
  - Second 8 points: all with ox=oy=1, i.e. the corners (81,61),(79,61),(79,59),(81,59), each twice.
  - Then done=1.
- radius=40, centre (0,0):
  - Only points with both coordinates >=0 assert plot; every other cycle has plot=0.
  - Total cycles from first PLOT to done equals 8*N.
  - Every (x,y) written satisfies |x^2+y^2-1600| <= 2*40.
- Reset pulled low mid-draw (radius=50) -> plot=0 and done=0 immediately; after release with start=0, no plot for 100 cycles; a new start redraws from oct 0.
- start held high through DONE -> done stays 1 and no second draw; start low for 1 cycle then high -> a second identical pixel sequence.
- start toggled and radius changed during PLOT -> pixel sequence is identical to an undisturbed run with the original radius.

Source files
------------

// File: rtl/circle_draw.sv
// circle_draw: midpoint circle rasteriser feeding the 160x120 VGA adapter
// pixel-write port. One octant point per clock; off-screen points are
// suppressed but still take their cycle, so draw time depends only on radius.
//
// state | meaning
// IDLE  | waiting for start; inputs latched when start=1
// INIT  | load ox=radius, oy=0, crit=1-radius, oct=0
// PLOT  | emit octant point oct; algorithm step after oct 7
// DONE  | done asserted; return to IDLE once start drops
module circle_draw #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       start,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] radius,
    input  logic [2:0] colour_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_PLOT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic signed [9:0] LP_W = 10'(SCREEN_W);
    localparam logic signed [9:0] LP_H = 10'(SCREEN_H);

    state_t r_state;
    state_t w_state_next;

    logic        [7:0]  r_cx;
    logic        [6:0]  r_cy;
    logic        [2:0]  r_col;
    logic signed [9:0]  r_ox;
    logic signed [9:0]  r_oy;
    logic signed [11:0] r_crit;
    logic        [2:0]  r_oct;

    logic        [7:0]  r_x;
    logic        [6:0]  r_y;
    logic        [2:0]  r_colour;
    logic               r_plot;
    logic               r_done;

    logic signed [9:0]  w_cx;
    logic signed [9:0]  w_cy;
    logic signed [9:0]  w_px;
    logic signed [9:0]  w_py;
    logic               w_on_screen;
    logic signed [9:0]  w_oy_upd;
    logic signed [9:0]  w_ox_upd;
    logic signed [11:0] w_oy_ext;
    logic signed [11:0] w_diff_ext;
    logic signed [11:0] w_crit_upd;
    logic               w_last_iter;
    logic               w_plot_next;
    logic               w_done_next;

    assign w_cx = {2'b00, r_cx};
    assign w_cy = {3'b000, r_cy};

    // Candidate pixel for the current octant, widened to 10-bit signed so
    // negative and past-the-edge coordinates can be detected.
    always_comb begin
        w_px = w_cx;
        w_py = w_cy;
        case (r_oct)
            3'd0: begin w_px = w_cx + r_ox; w_py = w_cy + r_oy; end
            3'd1: begin w_px = w_cx + r_oy; w_py = w_cy + r_ox; end
            3'd2: begin w_px = w_cx - r_ox; w_py = w_cy + r_oy; end
            3'd3: begin w_px = w_cx - r_oy; w_py = w_cy + r_ox; end
            3'd4: begin w_px = w_cx - r_ox; w_py = w_cy - r_oy; end
            3'd5: begin w_px = w_cx - r_oy; w_py = w_cy - r_ox; end
            3'd6: begin w_px = w_cx + r_ox; w_py = w_cy - r_oy; end
            default: begin w_px = w_cx + r_oy; w_py = w_cy - r_ox; end
        endcase
    end

    assign w_on_screen = !w_px[9] && (w_px < LP_W) && !w_py[9] && (w_py < LP_H);

    // Midpoint step applied after the eighth octant of each iteration.
    always_comb begin
        w_oy_upd   = r_oy + 10'sd1;
        w_ox_upd   = r_ox;
        w_oy_ext   = {{2{w_oy_upd[9]}}, w_oy_upd};
        w_diff_ext = w_oy_ext;
        if (r_crit[11] || (r_crit == 12'sd0)) begin
            w_crit_upd = r_crit + {w_oy_ext[10:0], 1'b0} + 12'sd1;
        end else begin
            w_ox_upd   = r_ox - 10'sd1;
            w_diff_ext = w_oy_ext - {{2{w_ox_upd[9]}}, w_ox_upd};
            w_crit_upd = r_crit + {w_diff_ext[10:0], 1'b0} + 12'sd1;
        end
    end

    assign w_last_iter = (w_oy_upd > w_ox_upd);

    // State register.
    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_INIT;
            S_INIT: w_state_next = S_PLOT;
            S_PLOT: if ((r_oct == 3'd7) && w_last_iter) w_state_next = S_DONE;
            S_DONE: if (!start) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode: strobe only for on-screen PLOT points; done from DONE.
    always_comb begin
        w_plot_next = (r_state == S_PLOT) && w_on_screen;
        w_done_next = (r_state == S_DONE);
    end

    // Input latch and algorithm registers.
    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            r_cx   <= '0;
            r_cy   <= '0;
            r_col  <= '0;
            r_ox   <= '0;
            r_oy   <= '0;
            r_crit <= '0;
            r_oct  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cx  <= centre_x;
                        r_cy  <= centre_y;
                        r_col <= colour_in;
                        r_ox  <= {2'b00, radius};
                    end
                end
                S_INIT: begin
                    r_oy   <= '0;
                    r_crit <= 12'sd1 - {4'b0000, r_ox[7:0]};
                    r_oct  <= '0;
                end
                S_PLOT: begin
                    r_oct <= r_oct + 3'd1;
                    if (r_oct == 3'd7) begin
                        r_oy   <= w_oy_upd;
                        r_ox   <= w_ox_upd;
                        r_crit <= w_crit_upd;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered adapter outputs; x/y/colour hold across suppressed points.
    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_plot <= w_plot_next;
            r_done <= w_done_next;
            if (w_plot_next) begin
                r_x      <= w_px[7:0];
                r_y      <= w_py[6:0];
                r_colour <= r_col;
            end
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign done   = r_done;

endmodule

// File: tb/tb_circle_draw.sv
// Scoreboard bench for circle_draw: a behavioural midpoint model queues the
// expected per-cycle adapter outputs, which are popped as the DUT draws.
module tb_circle_draw;

    logic       CLOCK_50 = 1'b0;
    logic       Reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] centre_x = '0;
    logic [6:0] centre_y = '0;
    logic [7:0] radius = '0;
    logic [2:0] colour_in = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       done;

    int n_vec = 0;
    int n_bad = 0;
    logic [19:0] sb_q[$];
    int m_x = 0;
    int m_y = 0;

    circle_draw #(.SCREEN_W(160), .SCREEN_H(120)) dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .start    (start),
        .centre_x (centre_x),
        .centre_y (centre_y),
        .radius   (radius),
        .colour_in(colour_in),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .done     (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {done, plot, x, y, colour-if-plotting}
    function automatic logic [19:0] obs();
        return {done, plot, x, y, (plot ? colour : 3'b000)};
    endfunction

    task automatic model_draw(input int cx, input int cy, input int r, input logic [2:0] col);
        int ox, oy, crit, px, py;
        bit running;
        ox = r; oy = 0; crit = 1 - r; running = 1'b1;
        while (running) begin
            for (int k = 0; k < 8; k++) begin
                case (k)
                    0: begin px = cx + ox; py = cy + oy; end
                    1: begin px = cx + oy; py = cy + ox; end
                    2: begin px = cx - ox; py = cy + oy; end
                    3: begin px = cx - oy; py = cy + ox; end
                    4: begin px = cx - ox; py = cy - oy; end
                    5: begin px = cx - oy; py = cy - ox; end
                    6: begin px = cx + ox; py = cy - oy; end
                    default: begin px = cx + oy; py = cy - ox; end
                endcase
                if (px >= 0 && px < 160 && py >= 0 && py < 120) begin
                    m_x = px; m_y = py;
                    sb_q.push_back({1'b0, 1'b1, 8'(px), 7'(py), col});
                end else begin
                    sb_q.push_back({1'b0, 1'b0, 8'(m_x), 7'(m_y), 3'b000});
                end
            end
            oy = oy + 1;
            if (crit <= 0) begin
                crit = crit + 2 * oy + 1;
            end else begin
                ox = ox - 1;
                crit = crit + 2 * (oy - ox) + 1;
            end
            if (oy > ox) running = 1'b0;
        end
    endtask

    task automatic run_draw(input int cx, input int cy, input int r, input logic [2:0] col,
                            input bit disturb, input bit circ, input string tag);
        int cyc, d;
        model_draw(cx, cy, r, col);
        centre_x = 8'(cx); centre_y = 7'(cy); radius = 8'(r); colour_in = col;
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        @(posedge CLOCK_50); #1;
        cyc = 0;
        while (sb_q.size() > 0) begin
            @(posedge CLOCK_50); #1;
            chk(tag, 32'(obs()), 32'(sb_q.pop_front()));
            if (circ && plot) begin
                d = (int'(x) - cx) * (int'(x) - cx) + (int'(y) - cy) * (int'(y) - cy) - r * r;
                chk({tag, "_circ"}, (d <= 2 * r && d >= -2 * r) ? 32'd1 : 32'd0, 32'd1);
            end
            if (disturb) begin
                if (cyc == 3) begin
                    start = 1'b0; radius = 8'd99; centre_x = 8'd10; colour_in = 3'd1;
                end
                if (cyc == 7) start = 1'b1;
            end
            cyc++;
        end
        @(posedge CLOCK_50); #1;
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
    endtask

    task automatic end_draw(input string tag);
        start = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        chk({tag, "_idle"}, {30'b0, done, plot}, 32'd0);
    endtask

    initial begin
        int nplot;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("reset_state", 32'(obs()), 32'd0);
        Reset = 1'b1;
        @(posedge CLOCK_50); #1;

        run_draw(80, 60, 0, 3'b101, 1'b0, 1'b0, "r0");
        end_draw("r0");
        run_draw(80, 60, 1, 3'b011, 1'b0, 1'b0, "r1");
        end_draw("r1");
        run_draw(0, 0, 40, 3'b110, 1'b0, 1'b1, "r40");
        end_draw("r40");

        centre_x = 8'd80; centre_y = 7'd60; radius = 8'd50; colour_in = 3'd4;
        start = 1'b1;
        repeat (30) @(posedge CLOCK_50);
        #4;
        Reset = 1'b0;
        #1;
        chk("rst_async", 32'(obs()), 32'd0);
        start = 1'b0;
        m_x = 0; m_y = 0;
        sb_q.delete();
        @(posedge CLOCK_50); #1;
        Reset = 1'b1;
        nplot = 0;
        repeat (100) begin
            @(posedge CLOCK_50); #1;
            if (plot || done) nplot++;
        end
        chk("rst_quiet", nplot, 0);
        run_draw(80, 60, 50, 3'd4, 1'b0, 1'b0, "r50");
        end_draw("r50");

        run_draw(100, 50, 10, 3'd2, 1'b0, 1'b0, "hold1");
        nplot = 0;
        repeat (20) begin
            @(posedge CLOCK_50); #1;
            if (plot || !done) nplot++;
        end
        chk("hold_done", nplot, 0);
        start = 1'b0;
        @(posedge CLOCK_50); #1;
        run_draw(100, 50, 10, 3'd2, 1'b0, 1'b0, "hold2");
        end_draw("hold2");

        run_draw(30, 100, 25, 3'd7, 1'b1, 1'b0, "disturb");
        end_draw("disturb");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
